cache_miss_handler: RTL

Miss-handling stage between the two-line fully associative write-back L1 cache and the direct-mapped RAM. On a cache miss it accepts one request and the cache's chosen victim line. It writes a dirty victim back to RAM, reads the missing word from RAM on a read miss, then returns a single fill beat for the cache to install. It also keeps saturating miss and write-back counters for the 7-segment display path.

---
 rtl/cache_miss_handler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cache_miss_handler.sv
// Miss handler between a two-line write-back L1 and a direct-mapped RAM: optional
// victim write-back, optional RAM read, then one fill beat; plus saturating counters.
module cache_miss_handler #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 8,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_address,
   input  logic [DATA_WIDTH-1:0] req_data,
   input  logic                  victim_dirty,
   input  logic [ADDR_WIDTH-1:0] victim_address,
   input  logic [DATA_WIDTH-1:0] victim_data,
   output logic                  fill_valid,
   output logic [ADDR_WIDTH-1:0] fill_address,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic                  fill_dirty,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_dataIn,
   output logic                  ram_write,
   input  logic [DATA_WIDTH-1:0] ram_dataOut,
   output logic [7:0]            miss_count,
   output logic [7:0]            wb_count
);

   // Handshake: a request transfers on a rising edge where req_valid and req_ready
   // are both high; req_* and victim_* are sampled only then, and req_valid is
   // ignored (not counted) while req_ready is low.
   typedef enum logic [1:0] {S_IDLE, S_WB, S_RD, S_FILL} state_t;

   localparam logic [2:0] RD_LOAD = 3'(RAM_LATENCY);

   state_t                state_q, state_d;
   logic                  req_write_q, req_write_d;
   logic [ADDR_WIDTH-1:0] req_address_q, req_address_d;
   logic [ADDR_WIDTH-1:0] victim_address_q, victim_address_d;
   logic [DATA_WIDTH-1:0] victim_data_q, victim_data_d;
   logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
   logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0] ram_dataIn_q, ram_dataIn_d;
   logic [2:0]            rd_cnt_q, rd_cnt_d;
   logic [7:0]            miss_count_q, miss_count_d;
   logic [7:0]            wb_count_q, wb_count_d;

   always_comb begin
      state_d          = state_q;
      req_write_d      = req_write_q;
      req_address_d    = req_address_q;
      victim_address_d = victim_address_q;
      victim_data_d    = victim_data_q;
      fill_data_d      = fill_data_q;
      rd_cnt_d         = rd_cnt_q;
      miss_count_d     = miss_count_q;
      wb_count_d       = wb_count_q;
      req_ready        = 1'b0;
      fill_valid       = 1'b0;
      fill_dirty       = 1'b0;
      ram_write        = 1'b0;
      ram_address      = ram_address_q;
      ram_dataIn       = ram_dataIn_q;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               req_write_d      = req_write;
               req_address_d    = req_address;
               victim_address_d = victim_address;
               victim_data_d    = victim_data;
               miss_count_d     = (miss_count_q == 8'hFF) ? 8'hFF : miss_count_q + 8'd1;
               // A write miss installs the store data directly; line = word.
               if (req_write) fill_data_d = req_data;
               if (victim_dirty) begin
                  state_d = S_WB;
               end else if (!req_write) begin
                  state_d  = S_RD;
                  rd_cnt_d = RD_LOAD;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_WB: begin
            ram_write   = 1'b1;
            ram_address = victim_address_q;
            ram_dataIn  = victim_data_q;
            wb_count_d  = (wb_count_q == 8'hFF) ? 8'hFF : wb_count_q + 8'd1;
            if (!req_write_q) begin
               state_d  = S_RD;
               rd_cnt_d = RD_LOAD;
            end else begin
               state_d = S_FILL;
            end
         end
         S_RD: begin
            // Address is held RAM_LATENCY+1 cycles; the word is taken on the last edge.
            ram_address = req_address_q;
            if (rd_cnt_q == 3'd0) begin
               fill_data_d = ram_dataOut;
               state_d     = S_FILL;
            end else begin
               rd_cnt_d = rd_cnt_q - 3'd1;
            end
         end
         S_FILL: begin
            fill_valid = 1'b1;
            fill_dirty = req_write_q;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      ram_address_d = ram_address;
      ram_dataIn_d  = ram_dataIn;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q          <= S_IDLE;
         req_write_q      <= 1'b0;
         req_address_q    <= '0;
         victim_address_q <= '0;
         victim_data_q    <= '0;
         fill_data_q      <= '0;
         ram_address_q    <= '0;
         ram_dataIn_q     <= '0;
         rd_cnt_q         <= '0;
         miss_count_q     <= '0;
         wb_count_q       <= '0;
      end else begin
         state_q          <= state_d;
         req_write_q      <= req_write_d;
         req_address_q    <= req_address_d;
         victim_address_q <= victim_address_d;
         victim_data_q    <= victim_data_d;
         fill_data_q      <= fill_data_d;
         ram_address_q    <= ram_address_d;
         ram_dataIn_q     <= ram_dataIn_d;
         rd_cnt_q         <= rd_cnt_d;
         miss_count_q     <= miss_count_d;
         wb_count_q       <= wb_count_d;
      end
   end

   assign fill_address = req_address_q;
   assign fill_data    = fill_data_q;
   assign miss_count   = miss_count_q;
   assign wb_count     = wb_count_q;

endmodule
